// File: rtl/mod_mul_serial.sv
// ---------------------------------------------------------------------------
// mod_mul_serial
//   Interleaved MSB-first bit-serial modular multiplier: result = a*b mod M.
//   On an accepted start the operands and type code are latched. The modulus
//   M is then requested from the modulus-fetch block. WIDTH shift/add/reduce
//   iterations follow, and the result is presented with a one-cycle done
//   pulse.
//
// Ports
//   clk        clock, all flops on the rising edge
//   RST        asynchronous, active-low reset
//   start      request pulse, sampled only while idle
//   type_code  modulus type selector, latched on an accepted start
//   a, b       operands, latched on an accepted start
//   mod_start  one-cycle fetch request to the modulus-fetch block
//   mod_type   latched type code, stable from start acceptance until idle
//   mod_data   modulus from the fetch block, valid while mod_done=1
//   mod_done   one-cycle pulse marking mod_data valid
//   result     a*b mod M, held until overwritten by the next completion
//   done       one-cycle completion pulse
//   err        invalid input (M==0, a>=M or b>=M), raised together with done
//   busy       high whenever the block is not idle
// ---------------------------------------------------------------------------
module mod_mul_serial #(
  parameter int WIDTH  = 256,
  parameter int TYPE_W = 5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [TYPE_W-1:0] type_code,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              mod_start,
  output logic [TYPE_W-1:0] mod_type,
  input  logic [WIDTH-1:0]  mod_data,
  input  logic              mod_done,
  output logic [WIDTH-1:0]  result,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAITM,
    S_CHECK,
    S_MUL,
    S_FIN
  } state_t;

  state_t            state, next_state;
  logic [WIDTH-1:0]  a_q, b_q, m_q, r_q;
  logic [CW-1:0]     count;
  logic [TYPE_W-1:0] type_q;
  logic              bad_q;
  logic              bad_in;

  // Datapath for one iteration, kept at WIDTH+2 bits until reduced.
  logic [WIDTH+1:0]  t_sum, m1, m2;
  logic [WIDTH-1:0]  r_next;

  assign mod_type = type_q;
  assign bad_in   = (m_q == '0) || (a_q >= m_q) || (b_q >= m_q);

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= next_state;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    mod_start  = 1'b0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_IDLE:  if (start) next_state = S_REQ;
      S_REQ: begin
        mod_start  = 1'b1;
        next_state = S_WAITM;
      end
      S_WAITM: if (mod_done) next_state = S_CHECK;
      S_CHECK: next_state = bad_in ? S_FIN : S_MUL;
      S_MUL:   if (count == '0) next_state = S_FIN;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // T = 2R + (A[i] ? B : 0). With R < M and B < M, T < 3M, so at most two
  // subtractions of M bring it back below M; testing 2M first does it in one.
  always_comb begin
    m1     = {2'b00, m_q};
    m2     = {1'b0, m_q, 1'b0};
    t_sum  = {1'b0, r_q, 1'b0} + {2'b00, (a_q[count] ? b_q : '0)};
    r_next = t_sum[WIDTH-1:0];
    if (t_sum >= m2)      r_next = WIDTH'(t_sum - m2);
    else if (t_sum >= m1) r_next = WIDTH'(t_sum - m1);
  end

  // NOTE: these are plain registers, not a memory array, so all of them are
  // cleared on reset and an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      r_q    <= '0;
      count  <= '0;
      type_q <= '0;
      bad_q  <= 1'b0;
      result <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          a_q    <= a;
          b_q    <= b;
          type_q <= type_code;
          r_q    <= '0;
          err    <= 1'b0;
          bad_q  <= 1'b0;
        end
        S_WAITM: if (mod_done) m_q <= mod_data;
        S_CHECK: begin
          bad_q <= bad_in;
          count <= CW'(WIDTH - 1);
        end
        S_MUL: begin
          r_q <= r_next;
          if (count != '0) count <= count - 1'b1;
        end
        // done is registered, so it appears the cycle the block is back in
        // idle: busy is already low and result/err are already valid.
        S_FIN: begin
          result <= bad_q ? '0 : r_q;
          err    <= bad_q;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_serial.sv
// ---------------------------------------------------------------------------
// tb_mod_mul_serial
//   Self-checking bench for mod_mul_serial. Acts as the modulus-fetch block
//   with a programmable latency and compares each result against a plain
//   arithmetic model (full product followed by %).
// ---------------------------------------------------------------------------
module tb_mod_mul_serial;

  localparam int W  = 256;
  localparam int TW = 5;

  logic          clk;
  logic          RST;
  logic          start;
  logic [TW-1:0] type_code;
  logic [W-1:0]  a, b;
  logic          mod_start;
  logic [TW-1:0] mod_type;
  logic [W-1:0]  mod_data;
  logic          mod_done;
  logic [W-1:0]  result;
  logic          done, err, busy;

  int checks   = 0;
  int failures = 0;

  mod_mul_serial #(.WIDTH(W), .TYPE_W(TW)) dut (
    .clk       (clk),
    .RST       (RST),
    .start     (start),
    .type_code (type_code),
    .a         (a),
    .b         (b),
    .mod_start (mod_start),
    .mod_type  (mod_type),
    .mod_data  (mod_data),
    .mod_done  (mod_done),
    .result    (result),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [W-1:0] m, input logic [W-1:0] av,
                                   input logic [W-1:0] bv);
    return (m == '0) || (av >= m) || (bv >= m);
  endfunction

  function automatic logic [W-1:0] ref_mulmod(input logic [W-1:0] m, input logic [W-1:0] av,
                                              input logic [W-1:0] bv);
    logic [2*W-1:0] p;
    if (ref_err(m, av, bv)) return '0;
    p = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
    return W'(p % {{W{1'b0}}, m});
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v = {v[W-33:0], 32'($urandom)};
    return v;
  endfunction

  // One operation: issue start, serve the modulus fetch with latency lat
  // (mod_done in the lat-th waiting cycle), optionally poke start while busy,
  // optionally pull reset asynchronously at cycle abort_at.
  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int lat, input bit poke, input int abort_at,
                       output logic [W-1:0] res, output logic e, output int cyc,
                       output int n_ms, output int n_done, output bit type_ok);
    logic [TW-1:0] t;
    int k;
    bit got;
    t = TW'($urandom);
    res = '0; e = 1'b0; cyc = -1; n_ms = 0; n_done = 0; type_ok = 1'b1; got = 1'b0;
    @(negedge clk);
    a = av; b = bv; type_code = t; start = 1'b1;
    @(negedge clk);
    k = 0;
    while (k < 2000 && !(got && k > cyc + 3)) begin
      if (mod_start) n_ms++;
      if (busy && mod_type !== t) type_ok = 1'b0;
      if (done) begin
        n_done++;
        if (!got) begin got = 1'b1; cyc = k; res = result; e = err; end
      end
      if (k == abort_at) begin
        start = 1'b0; mod_done = 1'b0;
        #2 RST = 1'b0;
        #1;
        check("abort_busy", W'(busy), '0);
        check("abort_done", W'(done), '0);
        check("abort_err", W'(err), '0);
        check("abort_result", result, '0);
        check("abort_mod_start", W'(mod_start), '0);
        check("abort_mod_type", W'(mod_type), '0);
        return;
      end
      mod_data = m;
      mod_done = (k == lat);
      start    = poke && (k == 5 || k == 100);
      @(negedge clk);
      k++;
    end
    start = 1'b0; mod_done = 1'b0;
    check("done_seen", W'(got), W'(1'b1));
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] m, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input int lat, input bit poke,
                           input logic [W-1:0] exp_res, input logic exp_err);
    logic [W-1:0] res;
    logic e;
    int cyc, n_ms, n_done;
    bit type_ok;
    int exp_cyc;
    do_op(m, av, bv, lat, poke, -1, res, e, cyc, n_ms, n_done, type_ok);
    exp_cyc = exp_err ? lat + 3 : lat + 3 + W;
    check($sformatf("%s_result", tag), res, exp_res);
    check($sformatf("%s_err", tag), W'(e), W'(exp_err));
    check($sformatf("%s_latency", tag), W'(cyc), W'(exp_cyc));
    check($sformatf("%s_mod_start_count", tag), W'(n_ms), W'(1));
    check($sformatf("%s_done_count", tag), W'(n_done), W'(1));
    check($sformatf("%s_mod_type_stable", tag), W'(type_ok), W'(1'b1));
  endtask

  initial begin
    logic [W-1:0] m25519, m, av, bv, res;
    logic e;
    int cyc, n_ms, n_done;
    bit type_ok;

    RST = 1'b0; start = 1'b0; type_code = '0; a = '0; b = '0;
    mod_data = '0; mod_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", result, '0);
    check("reset_done", W'(done), '0);
    check("reset_err", W'(err), '0);
    check("reset_busy", W'(busy), '0);
    check("reset_mod_start", W'(mod_start), '0);
    check("reset_mod_type", W'(mod_type), '0);
    RST = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases.
    run_check("basic", 256'd13, 256'd7, 256'd5, 10, 1'b0, 256'd9, 1'b0);
    run_check("max_ops", 256'd13, 256'd12, 256'd12, 3, 1'b0, 256'd1, 1'b0);
    run_check("zero_a", 256'd13, 256'd0, 256'd12, 1, 1'b0, 256'd0, 1'b0);
    m25519 = (256'd1 << 255) - 256'd19;
    run_check("full_width", m25519, 256'd2, 256'd1 << 254, 4, 1'b0, 256'd19, 1'b0);
    run_check("double_sub", m25519, m25519 - 1, m25519 - 1, 2, 1'b0, 256'd1, 1'b0);

    // Error paths; the following valid run must clear err.
    run_check("a_eq_m", 256'd13, 256'd13, 256'd1, 5, 1'b0, 256'd0, 1'b1);
    run_check("m_zero", 256'd0, 256'd3, 256'd4, 2, 1'b0, 256'd0, 1'b1);
    run_check("after_err", 256'd13, 256'd7, 256'd5, 2, 1'b0, 256'd9, 1'b0);

    // start re-pulsed during WAITM and MUL must be ignored.
    run_check("poke", 256'd13, 256'd11, 256'd6, 10, 1'b1, 256'd1, 1'b0);

    // Stray mod_done while idle: no state change, result held.
    @(negedge clk);
    mod_data = rand_word(); mod_done = 1'b1;
    @(negedge clk);
    mod_done = 1'b0;
    check("stray_busy", W'(busy), '0);
    check("stray_mod_start", W'(mod_start), '0);
    check("stray_result", result, 256'd1);
    repeat (2) @(negedge clk);
    check("stray_done", W'(done), '0);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 6; i++) begin
      m = rand_word() | 256'd1;
      if (i == 2) m = m >> ($urandom_range(200, 250));
      m = (m == '0) ? 256'd7 : m;
      av = rand_word() % m;
      bv = rand_word() % m;
      if (i == 5) av = m;
      run_check($sformatf("rand%0d", i), m, av, bv, int'($urandom_range(1, 8)), 1'b0,
                ref_mulmod(m, av, bv), ref_err(m, av, bv));
    end

    // Reset in the middle of MUL (iteration 100 with a 10-cycle fetch).
    do_op(256'd13, 256'd7, 256'd5, 10, 1'b0, 12 + 100, res, e, cyc, n_ms, n_done, type_ok);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    mod_data = 256'd99; mod_done = 1'b1;
    @(negedge clk);
    mod_done = 1'b0;
    check("post_reset_stray_busy", W'(busy), '0);
    check("post_reset_stray_done", W'(done), '0);
    run_check("after_reset", 256'd13, 256'd7, 256'd5, 10, 1'b0, 256'd9, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
